axi_lite_slave_mem: RTL and testbench

- AXI4-Lite slave with a word-addressed, byte-strobed internal memory.
- Directly downstream of the team's AXI master: consumes its AW/W/B and AR/R channels and returns write responses and read data.
- Write and read paths are independent FSMs and may run concurrently.
- Single outstanding transaction per direction.

---
 rtl/axi_lite_pkg.sv | 31 +++
 rtl/axi_lite_bram.sv | 54 +++++
 rtl/axi_lite_slave_mem.sv | 233 +++++++++++++++++++++++
 tb/tb_axi_lite_slave_mem.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Shared definitions for the AXI4-Lite slave memory.
//   - AXI response codes (OKAY / EXOKAY / SLVERR / DECERR)
//   - Write and read FSM state encodings
//   - resp_for(): maps an address-error flag to the response code
// ---------------------------------------------------------------------------
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_COMMIT = 2'd1,
    W_RESP   = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_t;

  function automatic logic [1:0] resp_for(input logic addr_err);
    return addr_err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_bram.sv
// ---------------------------------------------------------------------------
// axi_lite_bram
// Simple dual-port word memory, DEPTH_WORDS x WIDTH, one write port with a
// per-byte enable and one registered read port. No reset on the array or the
// read register.
// Ports:
//   clk      in   clock
//   we       in   write enable (qualified per lane by be)
//   be       in   byte enables, WIDTH/8
//   wr_idx   in   write word index
//   wr_data  in   write data
//   re       in   read enable; rd_data updates only when re is high
//   rd_idx   in   read word index
//   rd_data  out  registered read data
// Each byte lane is its own array so the lane write enables map directly
// onto independent RAM columns. Read and write to the same word on the same
// edge return the old contents (read-before-write).
// ---------------------------------------------------------------------------
module axi_lite_bram #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [WIDTH/8-1:0]             be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
  output logic [WIDTH-1:0]               rd_data
);

  localparam int NBYTES = WIDTH / 8;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          mem[wr_idx] <= wr_data[gi*8 +: 8];
        end
        if (re) begin
          q_reg <= mem[rd_idx];
        end
      end

      assign rd_data[gi*8 +: 8] = q_reg;
    end
  endgenerate

endmodule

// File: rtl/axi_lite_slave_mem.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_mem
// AXI4-Lite slave backed by a word-addressed, byte-strobed memory.
// Independent write (AW/W/B) and read (AR/R) FSMs, one outstanding
// transaction per direction.
// Ports:
//   ACLK, ARESETn                   clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY          write address channel
//   WDATA/WSTRB/WVALID/WREADY       write data channel
//   BRESP/BVALID/BREADY             write response channel
//   ARADDR/ARVALID/ARREADY          read address channel
//   RDATA/RRESP/RVALID/RREADY       read data channel
// Build option:
//   AXI_LITE_SLV_ADDR_CHECK_EN  defined   -> addresses at or above the memory
//                                            size answer SLVERR, the write is
//                                            dropped and RDATA reads 0.
//                               undefined -> upper address bits are ignored
//                                            (aliasing), always OKAY.
// ---------------------------------------------------------------------------
module axi_lite_slave_mem
  import axi_lite_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [WIDTH-1:0]   AWADDR,
  input  logic               AWVALID,
  output logic               AWREADY,
  input  logic [WIDTH-1:0]   WDATA,
  input  logic [WIDTH/8-1:0] WSTRB,
  input  logic               WVALID,
  output logic               WREADY,
  output logic [1:0]         BRESP,
  output logic               BVALID,
  input  logic               BREADY,
  input  logic [WIDTH-1:0]   ARADDR,
  input  logic               ARVALID,
  output logic               ARREADY,
  output logic [WIDTH-1:0]   RDATA,
  output logic [1:0]         RRESP,
  output logic               RVALID,
  input  logic               RREADY
);

  localparam int NBYTES   = WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NBYTES);
  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam int WADDR_W  = WIDTH - ADDR_LSB;

`ifdef AXI_LITE_SLV_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  // Byte-offset bits never select a word.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  // ------------------------------------------------------------------------
  // Write path
  // ------------------------------------------------------------------------
  w_state_t            w_state_reg;
  logic                awready_reg;
  logic                wready_reg;
  logic                bvalid_reg;
  logic [1:0]          bresp_reg;
  logic                aw_got_reg;
  logic                w_got_reg;
  logic [WADDR_W-1:0]  awaddr_reg;
  logic [WIDTH-1:0]    wdata_reg;
  logic [NBYTES-1:0]   wstrb_reg;

  logic aw_hs;
  logic w_hs;
  logic aw_have;
  logic w_have;
  logic wr_err;
  logic mem_we;

  assign aw_hs   = AWVALID && awready_reg;
  assign w_hs    = WVALID && wready_reg;
  // "Have" includes a handshake landing on this very edge, so AW and W on the
  // same edge go straight to commit.
  assign aw_have = aw_got_reg || aw_hs;
  assign w_have  = w_got_reg || w_hs;
  assign wr_err  = ADDR_CHECK && (|awaddr_reg[WADDR_W-1:IDX_W]);
  assign mem_we  = (w_state_reg == W_COMMIT) && !wr_err;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_reg <= W_IDLE;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      aw_got_reg  <= 1'b0;
      w_got_reg   <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      case (w_state_reg)
        W_IDLE: begin
          if (aw_hs) begin
            awaddr_reg <= AWADDR[WIDTH-1:ADDR_LSB];
            aw_got_reg <= 1'b1;
          end
          if (w_hs) begin
            wdata_reg <= WDATA;
            wstrb_reg <= WSTRB;
            w_got_reg <= 1'b1;
          end
          // Readys come up on the first edge in IDLE (including right after
          // reset) and drop for good once their channel has been taken.
          awready_reg <= !aw_have;
          wready_reg  <= !w_have;
          if (aw_have && w_have) begin
            w_state_reg <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          // The memory write happens on this same edge via mem_we.
          bvalid_reg  <= 1'b1;
          bresp_reg   <= resp_for(wr_err);
          aw_got_reg  <= 1'b0;
          w_got_reg   <= 1'b0;
          w_state_reg <= W_RESP;
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            w_state_reg <= W_IDLE;
          end
        end
        default: begin
          w_state_reg <= W_IDLE;
        end
      endcase
    end
  end

  assign AWREADY = awready_reg;
  assign WREADY  = wready_reg;
  assign BVALID  = bvalid_reg;
  assign BRESP   = bresp_reg;

  // ------------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------------
  r_state_t            r_state_reg;
  logic                arready_reg;
  logic                rvalid_reg;
  logic [1:0]          rresp_reg;
  logic                rd_err_reg;
  logic [WADDR_W-1:0]  araddr_reg;

  logic ar_hs;
  logic rd_err;
  logic mem_re;
  logic [WIDTH-1:0] mem_q;

  assign ar_hs  = ARVALID && arready_reg;
  assign rd_err = ADDR_CHECK && (|araddr_reg[WADDR_W-1:IDX_W]);
  assign mem_re = (r_state_reg == R_FETCH);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_reg <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rresp_reg   <= RESP_OKAY;
      rd_err_reg  <= 1'b0;
      araddr_reg  <= '0;
    end else begin
      case (r_state_reg)
        R_IDLE: begin
          if (ar_hs) begin
            araddr_reg  <= ARADDR[WIDTH-1:ADDR_LSB];
            arready_reg <= 1'b0;
            r_state_reg <= R_FETCH;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_FETCH: begin
          // RAM read register loads on this same edge via mem_re.
          rvalid_reg  <= 1'b1;
          rresp_reg   <= resp_for(rd_err);
          rd_err_reg  <= rd_err;
          r_state_reg <= R_DATA;
        end
        R_DATA: begin
          if (RREADY) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
            r_state_reg <= R_IDLE;
          end
        end
        default: begin
          r_state_reg <= R_IDLE;
        end
      endcase
    end
  end

  // The RAM read register carries no reset, so RDATA is qualified by two
  // registered flags: it reads 0 out of reset, outside a response and on an
  // error response, and otherwise shows the held RAM output.
  assign RDATA  = (rvalid_reg && !rd_err_reg) ? mem_q : '0;
  assign RRESP  = rresp_reg;
  assign RVALID = rvalid_reg;
  assign ARREADY = arready_reg;

  axi_lite_bram #(
    .WIDTH       (WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_bram (
    .clk     (ACLK),
    .we      (mem_we),
    .be      (wstrb_reg),
    .wr_idx  (awaddr_reg[IDX_W-1:0]),
    .wr_data (wdata_reg),
    .re      (mem_re),
    .rd_idx  (araddr_reg[IDX_W-1:0]),
    .rd_data (mem_q)
  );

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
module tb_axi_lite_slave_mem;

  localparam int WIDTH = 32;

  logic              ACLK;
  logic              ARESETn;
  logic [WIDTH-1:0]  AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [WIDTH-1:0]  WDATA;
  logic [3:0]        WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [WIDTH-1:0]  ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [WIDTH-1:0]  RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  int n_checks;
  int n_fail;

  axi_lite_slave_mem #(
    .WIDTH       (WIDTH),
    .DEPTH_WORDS (1024)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Advance to 1ns after the next rising edge; inputs are driven and outputs
  // sampled there.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    bit aw_pend;
    bit w_pend;
    bit aw_rdy;
    bit w_rdy;
    int cyc;
    AWADDR = addr; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    BREADY = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1; cyc = 0; resp = 2'bxx;
    while (!BVALID && cyc < 20) begin
      aw_rdy = AWREADY;
      w_rdy = WREADY;
      tick();
      cyc++;
      if (aw_pend && aw_rdy) begin AWVALID = 1'b0; aw_pend = 1'b0; end
      if (w_pend && w_rdy) begin WVALID = 1'b0; w_pend = 1'b0; end
    end
    if (BVALID) begin
      resp = BRESP;
      tick();
    end else begin
      n_checks++; n_fail++;
      $display("FAIL write_timeout: addr=%h no BVALID after %0d cycles (required within 20)", addr, cyc);
      AWVALID = 1'b0; WVALID = 1'b0;
    end
    $display("WR addr=%h data=%h strb=%b resp=%b", addr, data, strb, resp);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    bit ar_pend;
    bit ar_rdy;
    int cyc;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    ar_pend = 1'b1; cyc = 0; data = 'x; resp = 2'bxx;
    while (!RVALID && cyc < 20) begin
      ar_rdy = ARREADY;
      tick();
      cyc++;
      if (ar_pend && ar_rdy) begin ARVALID = 1'b0; ar_pend = 1'b0; end
    end
    if (RVALID) begin
      data = RDATA;
      resp = RRESP;
      tick();
    end else begin
      n_checks++; n_fail++;
      $display("FAIL read_timeout: addr=%h no RVALID after %0d cycles (required within 20)", addr, cyc);
      ARVALID = 1'b0;
    end
    $display("RD addr=%h data=%h resp=%b", addr, data, resp);
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      n_fail++; $display("FAIL reset_readys: got %b required 000", {AWREADY, WREADY, ARREADY});
    end
    n_checks++;
    if ({BVALID, RVALID} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valids: got %b required 00", {BVALID, RVALID});
    end
    n_checks++;
    if ({BRESP, RRESP} !== 4'b0000 || RDATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_resp_data: got resp=%b rdata=%h required 0000/0", {BRESP, RRESP}, RDATA);
    end
    ARESETn = 1'b1;
    tick();
    n_checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      n_fail++; $display("FAIL readys_after_reset: got %b required 111", {AWREADY, WREADY, ARREADY});
    end
    $display("RESET released, readys=%b", {AWREADY, WREADY, ARREADY});
  endtask

  task automatic test_same_edge();
    AWADDR = 32'h10; AWVALID = 1'b1;
    WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    tick();  // edge N: AW and W handshake together
    AWVALID = 1'b0; WVALID = 1'b0;
    n_checks++;
    if ({AWREADY, WREADY, BVALID} !== 3'b000) begin
      n_fail++; $display("FAIL same_edge_after_hs: aw/w/b got %b required 000", {AWREADY, WREADY, BVALID});
    end
    tick();  // edge N+1: commit
    n_checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
      n_fail++; $display("FAIL same_edge_bvalid: got bvalid=%b bresp=%b required 1/00", BVALID, BRESP);
    end
    tick();  // edge N+2: retire
    n_checks++;
    if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
      n_fail++; $display("FAIL same_edge_retire: b/aw/w got %b required 011", {BVALID, AWREADY, WREADY});
    end
    $display("WR addr=00000010 data=deadbeef strb=1111 (same edge)");

    ARADDR = 32'h10; ARVALID = 1'b1; RREADY = 1'b1;
    tick();  // AR handshake
    ARVALID = 1'b0;
    n_checks++;
    if (ARREADY !== 1'b0 || RVALID !== 1'b0) begin
      n_fail++; $display("FAIL read_after_ar: arready=%b rvalid=%b required 0/0", ARREADY, RVALID);
    end
    tick();  // fetch
    n_checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF || RRESP !== 2'b00) begin
      n_fail++; $display("FAIL read_data_10: got rvalid=%b rdata=%h rresp=%b required 1/deadbeef/00", RVALID, RDATA, RRESP);
    end
    tick();
    n_checks++;
    if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      n_fail++; $display("FAIL read_retire: rvalid=%b arready=%b required 0/1", RVALID, ARREADY);
    end
    $display("RD addr=00000010 data=%h", 32'hDEADBEEF);
  endtask

  task automatic test_w_before_aw();
    logic [31:0] d;
    logic [1:0] r;
    WDATA = 32'h11223344; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    tick();  // W handshake
    WVALID = 1'b0;
    n_checks++;
    if (WREADY !== 1'b0 || AWREADY !== 1'b1) begin
      n_fail++; $display("FAIL w_first_readys: wready=%b awready=%b required 0/1", WREADY, AWREADY);
    end
    tick();
    tick();
    n_checks++;
    if (WREADY !== 1'b0 || BVALID !== 1'b0) begin
      n_fail++; $display("FAIL w_first_waiting: wready=%b bvalid=%b required 0/0", WREADY, BVALID);
    end
    AWADDR = 32'h20; AWVALID = 1'b1;
    tick();  // AW handshake, 3 edges after W
    AWVALID = 1'b0;
    n_checks++;
    if (AWREADY !== 1'b0 || BVALID !== 1'b0) begin
      n_fail++; $display("FAIL w_first_aw_hs: awready=%b bvalid=%b required 0/0", AWREADY, BVALID);
    end
    tick();  // commit
    n_checks++;
    if (BVALID !== 1'b1) begin
      n_fail++; $display("FAIL w_first_bvalid: got %b required 1", BVALID);
    end
    tick();
    $display("WR addr=00000020 data=11223344 strb=1111 (W first)");
    do_read(32'h20, d, r);
    n_checks++;
    if (d !== 32'h11223344 || r !== 2'b00) begin
      n_fail++; $display("FAIL w_first_readback: got %h/%b required 11223344/00", d, r);
    end
  endtask

  task automatic test_partial_strobe();
    logic [31:0] d;
    logic [1:0] r;
    do_write(32'h20, 32'hAABBCCDD, 4'b0101, r);
    n_checks++;
    if (r !== 2'b00) begin
      n_fail++; $display("FAIL strobe_bresp: got %b required 00", r);
    end
    do_read(32'h20, d, r);
    n_checks++;
    if (d !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL strobe_readback: got %h required 11bb33dd", d);
    end
    do_write(32'h20, 32'hFFFFFFFF, 4'b0000, r);
    do_read(32'h20, d, r);
    n_checks++;
    if (d !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL strobe_zero_noop: got %h required 11bb33dd", d);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [1:0] r;
    AWADDR = 32'h40; AWVALID = 1'b1;
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
    ARADDR = 32'h10; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || RVALID !== 1'b1 || RDATA !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL bp_hold[%0d]: b=%b bresp=%b r=%b rdata=%h required 1/00/1/deadbeef", i, BVALID, BRESP, RVALID, RDATA);
      end
      n_checks++;
      if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
        n_fail++; $display("FAIL bp_readys[%0d]: got %b required 000", i, {AWREADY, WREADY, ARREADY});
      end
    end
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    n_checks++;
    if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b00111) begin
      n_fail++; $display("FAIL bp_release: b/r/aw/w/ar got %b required 00111", {BVALID, RVALID, AWREADY, WREADY, ARREADY});
    end
    $display("WR addr=00000040 data=cafef00d / RD addr=00000010 (backpressured 5 cycles)");
    do_read(32'h40, d, r);
    n_checks++;
    if (d !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL bp_readback: got %h required cafef00d", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic [1:0] r;
    do_write(32'h30, 32'h0, 4'hF, r);
    AWADDR = 32'h30; AWVALID = 1'b1;
    WDATA = 32'h55; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
    ARADDR = 32'h30; ARVALID = 1'b1; RREADY = 1'b1;
    tick();  // all handshakes
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    tick();  // commit edge == fetch edge
    n_checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'h0 || BVALID !== 1'b1) begin
      n_fail++; $display("FAIL collision_old_data: rvalid=%b rdata=%h bvalid=%b required 1/00000000/1", RVALID, RDATA, BVALID);
    end
    tick();
    $display("WR addr=00000030 data=00000055 / RD addr=00000030 same edge");
    do_read(32'h30, d, r);
    n_checks++;
    if (d !== 32'h55) begin
      n_fail++; $display("FAIL collision_new_data: got %h required 00000055", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0] r;
    AWADDR = 32'h50; AWVALID = 1'b1; BREADY = 1'b1;
    tick();  // AW latched, W not yet
    AWVALID = 1'b0;
    ARESETn = 1'b0;
    #1;
    n_checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      n_fail++; $display("FAIL async_reset_readys: got %b required 000", {AWREADY, WREADY, ARREADY});
    end
    tick();
    ARESETn = 1'b1;
    tick();
    WDATA = 32'h77; WSTRB = 4'hF; WVALID = 1'b1;
    tick();  // only W arrives: the dropped AW must not complete the write
    WVALID = 1'b0;
    tick();
    tick();
    n_checks++;
    if (BVALID !== 1'b0 || AWREADY !== 1'b1) begin
      n_fail++; $display("FAIL reset_drops_aw: bvalid=%b awready=%b required 0/1", BVALID, AWREADY);
    end
    AWADDR = 32'h50; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    tick();
    n_checks++;
    if (BVALID !== 1'b1) begin
      n_fail++; $display("FAIL reset_then_write: bvalid=%b required 1", BVALID);
    end
    tick();
    $display("WR addr=00000050 data=00000077 (after mid-transaction reset)");
    do_read(32'h50, d, r);
    n_checks++;
    if (d !== 32'h77) begin
      n_fail++; $display("FAIL reset_then_readback: got %h required 00000077", d);
    end
  endtask

  task automatic test_addr_range();
    logic [31:0] d;
    logic [1:0] r;
    do_write(32'h0, 32'h12345678, 4'hF, r);
    do_write(32'h1000, 32'hFFFFFFFF, 4'hF, r);
`ifdef AXI_LITE_SLV_ADDR_CHECK_EN
    n_checks++;
    if (r !== 2'b10) begin
      n_fail++; $display("FAIL oor_bresp: got %b required 10", r);
    end
    do_read(32'h1000, d, r);
    n_checks++;
    if (r !== 2'b10 || d !== 32'h0) begin
      n_fail++; $display("FAIL oor_read: got %h/%b required 00000000/10", d, r);
    end
    do_read(32'h0, d, r);
    n_checks++;
    if (d !== 32'h12345678) begin
      n_fail++; $display("FAIL oor_word0_kept: got %h required 12345678", d);
    end
`else
    n_checks++;
    if (r !== 2'b00) begin
      n_fail++; $display("FAIL alias_bresp: got %b required 00", r);
    end
    do_read(32'h1000, d, r);
    n_checks++;
    if (r !== 2'b00 || d !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL alias_read: got %h/%b required ffffffff/00", d, r);
    end
    do_read(32'h0, d, r);
    n_checks++;
    if (d !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL alias_word0: got %h required ffffffff", d);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_same_edge();
    test_w_before_aw();
    test_partial_strobe();
    test_backpressure();
    test_collision();
    test_reset_mid();
    test_addr_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
